angle_gen: RTL and testbench

//  Phase-accumulator (NCO) angle source. Directly upstream of the complex

---
 rtl/angle_gen_if.sv | 30 +++
 rtl/angle_gen.sv | 85 ++++++++
 tb/tb_angle_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/angle_gen_if.sv
// Control/config and angle-stream bundle between the NCO angle source and its user.
// Control inputs are sampled on rising clk; all outputs are registered in angle_gen.
interface angle_gen_if #(
   parameter int ACC_W = 20,
   parameter int ANG_W = 12
);
   logic             start;
   logic             stop;
   logic             sweep_en;
   logic [ACC_W-1:0] freq_start;
   logic [ACC_W-1:0] freq_inc;
   logic [ACC_W-1:0] freq_stop;
   logic [ANG_W-1:0] phase_off;
   logic [ANG_W-1:0] angle;
   logic             angle_valid;
   logic             busy;
   logic             sweep_done;
   logic [1:0]       state_dbg;

   // Handshake: angle is a live sample exactly in cycles where angle_valid=1;
   // there is no back-pressure, the consumer must accept every valid sample.
   modport master (
      output start, stop, sweep_en, freq_start, freq_inc, freq_stop, phase_off,
      input  angle, angle_valid, busy, sweep_done, state_dbg
   );
   modport slave (
      input  start, stop, sweep_en, freq_start, freq_inc, freq_stop, phase_off,
      output angle, angle_valid, busy, sweep_done, state_dbg
   );
endinterface

// File: rtl/angle_gen.sv
// Phase-accumulator angle source with fixed-frequency and linear-chirp modes.
// angle = acc[top ANG_W bits] + phase_off, one live sample per clock while busy.
module angle_gen #(
   parameter int ACC_W = 20,
   parameter int ANG_W = 12
) (
   input logic        clk,
   input logic        rst,
   angle_gen_if.slave nco
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SWEEP = 2'd2} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] freq;
   logic [ACC_W-1:0] inc_r;
   logic [ACC_W-1:0] stop_r;
   logic [ANG_W-1:0] phase_r;
   logic [ANG_W-1:0] angle_r;
   logic             valid_r;
   logic             busy_r;
   logic             done_r;
   logic [ACC_W:0]   nxt;

   // One extra bit so the chirp step can never wrap past freq_stop.
   assign nxt = {1'b0, freq} + {1'b0, inc_r};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         freq    <= '0;
         inc_r   <= '0;
         stop_r  <= '0;
         phase_r <= '0;
         angle_r <= '0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (nco.stop) begin
            state   <= IDLE;
            acc     <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
         end else begin
            if (state == IDLE) begin
               valid_r <= 1'b0;
               acc     <= '0;
            end else begin
               angle_r <= acc[ACC_W-1 -: ANG_W] + phase_r;
               valid_r <= 1'b1;
               acc     <= acc + freq;
            end
            if (state == SWEEP) begin
               if (nxt >= {1'b0, stop_r}) begin
                  freq   <= stop_r;
                  done_r <= 1'b1;
                  state  <= RUN;
               end else begin
                  freq <= nxt[ACC_W-1:0];
               end
            end
            // A restart still emits the old run's sample this edge, so the
            // valid stream has no gap; the new config takes over next edge.
            if (nco.start) begin
               inc_r   <= nco.freq_inc;
               stop_r  <= nco.freq_stop;
               phase_r <= nco.phase_off;
               freq    <= nco.freq_start;
               acc     <= '0;
               state   <= nco.sweep_en ? SWEEP : RUN;
               busy_r  <= 1'b1;
            end
         end
      end
   end

   assign nco.angle       = angle_r;
   assign nco.angle_valid = valid_r;
   assign nco.busy        = busy_r;
   assign nco.sweep_done  = done_r;
   assign nco.state_dbg   = state;
endmodule

// File: tb/tb_angle_gen.sv
// Randomized bench for angle_gen: a closed-form per-sample reference feeds an
// expected queue; a monitor compares every valid angle against it.
module tb_angle_gen;
   localparam int ACC_W = 20;
   localparam int ANG_W = 12;
   localparam int W     = ANG_W + 1;

   logic clk;
   logic rst;
   angle_gen_if #(.ACC_W(ACC_W), .ANG_W(ANG_W)) nco ();

   angle_gen #(.ACC_W(ACC_W), .ANG_W(ANG_W)) dut (.clk(clk), .rst(rst), .nco(nco));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int samples  = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: sample n of a run is a closed-form function of the config
   logic         m_active;
   logic         m_sw;
   longint       m_fs, m_fi, m_fst, m_po, m_dn, m_sum, m_n;
   logic [ANG_W-1:0] m_last;

   function automatic longint first_done(longint fs, longint fi, longint fst);
      if (fs >= fst) return 1;
      if (fi == 0) return 64'h7fff_ffff_ffff;
      return (fst - fs + fi - 1) / fi;
   endfunction

   function automatic longint freq_of(longint j);
      if (!m_sw) return m_fs;
      if (j < m_dn) return m_fs + j * m_fi;
      return m_fst;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_last   = '0;
         exp_q.delete();
      end else if (nco.stop) begin
         m_active = 1'b0;
      end else begin
         if (m_active) begin
            logic [ANG_W-1:0] a;
            logic d;
            a = ANG_W'((((m_sum % (64'd1 << ACC_W)) >> (ACC_W - ANG_W)) + m_po) % (64'd1 << ANG_W));
            d = m_sw && (m_n == m_dn);
            exp_q.push_back({d, a});
            m_last = a;
            m_sum  = m_sum + freq_of(m_n - 1);
            m_n    = m_n + 1;
         end
         if (nco.start) begin
            m_sw     = nco.sweep_en;
            m_fs     = longint'(nco.freq_start);
            m_fi     = longint'(nco.freq_inc);
            m_fst    = longint'(nco.freq_stop);
            m_po     = longint'(nco.phase_off);
            m_dn     = first_done(m_fs, m_fi, m_fst);
            m_sum    = 0;
            m_n      = 1;
            m_active = 1'b1;
         end
      end
   end

   // monitor: outputs are sampled on the falling edge
   logic mon_en = 1'b0;
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (nco.angle_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'(nco.angle_valid), 32'd0);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               samples++;
               check("angle", 32'(nco.angle), 32'(e[ANG_W-1:0]));
               check("sweep_done", 32'(nco.sweep_done), 32'(e[ANG_W]));
            end
         end else begin
            check("done_without_valid", 32'(nco.sweep_done), 32'd0);
            if (!m_active) check("idle_angle_hold", 32'(nco.angle), 32'(m_last));
         end
         check("busy", 32'(nco.busy), 32'(m_active));
      end
   end

   // driver tasks
   task automatic step(input logic s, input logic p, input logic sw,
                       input logic [ACC_W-1:0] fs, input logic [ACC_W-1:0] fi,
                       input logic [ACC_W-1:0] fst, input logic [ANG_W-1:0] po);
      nco.start      = s;
      nco.stop       = p;
      nco.sweep_en   = sw;
      nco.freq_start = fs;
      nco.freq_inc   = fi;
      nco.freq_stop  = fst;
      nco.phase_off  = po;
      @(negedge clk);
   endtask

   task automatic noise(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'($urandom), ACC_W'($urandom), ACC_W'($urandom),
              ACC_W'($urandom), ANG_W'($urandom));
   endtask

   task automatic rand_start(input logic p);
      logic sw;
      sw = 1'($urandom_range(0, 1));
      if (sw)
         step(1'b1, p, 1'b1, ACC_W'($urandom_range(0, 'h2000)),
              ($urandom_range(0, 3) == 0) ? '0 : ACC_W'($urandom_range(1, 'h800)),
              ACC_W'($urandom_range(0, 'h8000)), ANG_W'($urandom));
      else
         step(1'b1, p, 1'b0, ACC_W'($urandom), ACC_W'($urandom),
              ACC_W'($urandom), ANG_W'($urandom));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_angle"}, 32'(nco.angle), 32'd0);
      check({tag, "_valid"}, 32'(nco.angle_valid), 32'd0);
      check({tag, "_busy"}, 32'(nco.busy), 32'd0);
      check({tag, "_done"}, 32'(nco.sweep_done), 32'd0);
      check({tag, "_state"}, 32'(nco.state_dbg), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      nco.start = 1'b0; nco.stop = 1'b0; nco.sweep_en = 1'b0;
      nco.freq_start = '0; nco.freq_inc = '0; nco.freq_stop = '0; nco.phase_off = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      mon_en = 1'b1;
      noise(3);

      // fixed quarter-turn step, then offset that wraps, restarted with no gap
      step(1'b1, 1'b0, 1'b0, 20'h40000, 20'h0, 20'h0, 12'h000);
      noise(6);
      step(1'b1, 1'b0, 1'b0, 20'h40000, 20'h0, 20'h0, 12'hC00);
      noise(5);
      step(1'b1, 1'b0, 1'b0, 20'h40000, 20'h0, 20'h0, 12'h005);
      noise(3);

      // chirp 0x100 -> 0x400 in 0x100 steps
      step(1'b1, 1'b0, 1'b1, 20'h100, 20'h100, 20'h400, 12'h000);
      noise(8);
      // start and stop together: stop wins
      step(1'b1, 1'b1, 1'b0, 20'h12345, 20'h0, 20'h0, 12'h0AB);
      noise(4);
      // degenerate sweeps: start above stop, zero increment
      step(1'b1, 1'b0, 1'b1, 20'h900, 20'h10, 20'h400, 12'h001);
      noise(4);
      step(1'b1, 1'b0, 1'b1, 20'h300, 20'h0, 20'h400, 12'h002);
      noise(6);

      // async reset mid-sweep, between edges
      step(1'b1, 1'b0, 1'b1, 20'h100, 20'h40, 20'h4000, 12'h123);
      noise(5);
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      noise(5);

      // randomized runs with random restarts and stops
      for (int it = 0; it < 30; it++) begin
         rand_start(1'b0);
         for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4)       step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
            else if (r < 9)  rand_start(1'b0);
            else if (r < 11) rand_start(1'b1);
            else             noise(1);
         end
      end
      step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
      noise(3);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      if (samples < 100) check("sample_count_low", 32'(samples), 32'd100);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
